// File: rtl/alu_result_monitor.sv
// Passive monitor for a start/done ALU handshake: captures each valid command,
// waits for done or a timeout, and logs a checked 40-bit record per command.
module alu_result_monitor #(
  parameter int BATCH   = 100,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [2:0]                 op_i,
  input  logic [7:0]                 a_i,
  input  logic [7:0]                 b_i,
  input  logic                       done_i,
  input  logic [15:0]                result_i,
  input  logic                       clear_i,
  output logic [BATCH*40-1:0]        rec_buf_o,
  output logic [$clog2(BATCH+1)-1:0] rec_cnt_o,
  output logic                       full_o,
  output logic [15:0]                mismatch_cnt_o,
  output logic                       timeout_o
);
  localparam int CNT_W = $clog2(BATCH + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] BATCH_C  = CNT_W'(BATCH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;
  logic [7:0]       a_reg;
  logic [7:0]       b_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             full_reg;
  logic [15:0]      mis_reg;
  logic             to_reg;

  logic             cmd_ok;
  logic             timer_hit;
  logic             rec_wr;
  logic             rec_bad;
  logic [15:0]      expected;
  logic [15:0]      rec_result;
  logic [39:0]      rec_data;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    expected = 16'h0000;
    case (op_reg)
      3'd1:    expected = {7'd0, {1'b0, a_reg} + {1'b0, b_reg}};
      3'd2:    expected = {8'd0, a_reg & b_reg};
      3'd3:    expected = {8'd0, a_reg ^ b_reg};
      3'd4:    expected = {8'd0, a_reg} * {8'd0, b_reg};
      default: expected = 16'h0000;
    endcase
  end

  assign cmd_ok     = start_i && (op_i != 3'd0) && (op_i <= 3'd4) && !full_reg;
  assign timer_hit  = (timer_reg == TMR_LAST);
  // done wins over a timeout landing on the same edge; clear suppresses both
  assign rec_wr     = (state_reg == WAIT_DONE) && !clear_i && (done_i || timer_hit);
  assign rec_result = done_i ? result_i : 16'hFFFF;
  assign rec_bad    = !done_i || (result_i != expected);
  assign rec_data   = {rec_result, b_reg, a_reg, 5'd0, op_reg};
  assign cnt_inc    = cnt_reg + CNT_W'(1);

  generate
    for (genvar gi = 0; gi < BATCH; gi++) begin : g_rec
      logic [39:0] rec_reg;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          rec_reg <= '0;
        end else if (clear_i) begin
          rec_reg <= '0;
        end else if (rec_wr && (cnt_reg == CNT_W'(gi))) begin
          rec_reg <= rec_data;
        end
      end

      assign rec_buf_o[gi*40 +: 40] = rec_reg;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      timer_reg <= '0;
      cnt_reg   <= '0;
      full_reg  <= 1'b0;
      mis_reg   <= '0;
      to_reg    <= 1'b0;
    end else if (clear_i) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      cnt_reg   <= '0;
      full_reg  <= 1'b0;
      mis_reg   <= '0;
      to_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_ok) begin
            op_reg    <= op_i;
            a_reg     <= a_i;
            b_reg     <= b_i;
            timer_reg <= '0;
            state_reg <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (rec_wr) begin
            cnt_reg  <= cnt_inc;
            full_reg <= (cnt_inc == BATCH_C);
            if (rec_bad && (mis_reg != 16'hFFFF)) begin
              mis_reg <= mis_reg + 16'd1;
            end
            if (!done_i) begin
              to_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rec_cnt_o      = cnt_reg;
  assign full_o         = full_reg;
  assign mismatch_cnt_o = mis_reg;
  assign timeout_o      = to_reg;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Randomized and directed bench for alu_result_monitor against a record-list
// model derived from the ALU opcode arithmetic.
module tb_alu_result_monitor;
  localparam int BATCH   = 100;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(BATCH + 1);

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 start_i;
  logic [2:0]           op_i;
  logic [7:0]           a_i;
  logic [7:0]           b_i;
  logic                 done_i;
  logic [15:0]          result_i;
  logic                 clear_i;
  logic [BATCH*40-1:0]  rec_buf_o;
  logic [CW-1:0]        rec_cnt_o;
  logic                 full_o;
  logic [15:0]          mismatch_cnt_o;
  logic                 timeout_o;

  alu_result_monitor #(.BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .done_i         (done_i),
    .result_i       (result_i),
    .clear_i        (clear_i),
    .rec_buf_o      (rec_buf_o),
    .rec_cnt_o      (rec_cnt_o),
    .full_o         (full_o),
    .mismatch_cnt_o (mismatch_cnt_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [39:0] m_rec [BATCH];
  int          m_cnt;
  int          m_mis;
  logic        m_to;

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd1:    return 16'(ia + ib);
      3'd2:    return 16'(ia & ib);
      3'd3:    return 16'(ia ^ ib);
      3'd4:    return 16'(ia * ib);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_mis = 0;
    m_to  = 1'b0;
    for (int k = 0; k < BATCH; k++) m_rec[k] = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_buf(input string tag);
    logic [BATCH*40-1:0] exp_buf;
    exp_buf = '0;
    for (int k = 0; k < m_cnt; k++) exp_buf[k*40 +: 40] = m_rec[k];
    n_checks++;
    assert (rec_buf_o === exp_buf) else begin
      n_errors++;
      for (int k = 0; k < BATCH; k++) begin
        if (rec_buf_o[k*40 +: 40] !== exp_buf[k*40 +: 40]) begin
          $error("FAIL %s: record %0d got %h expected %h", tag, k,
                 rec_buf_o[k*40 +: 40], exp_buf[k*40 +: 40]);
          break;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cnt"}, 64'(rec_cnt_o), 64'(m_cnt));
    check({tag, "_mis"}, 64'(mismatch_cnt_o), 64'(m_mis));
    check({tag, "_timeout"}, 64'(timeout_o), 64'(m_to));
    check({tag, "_full"}, 64'(full_o), 64'(m_cnt == BATCH));
    check_buf({tag, "_buf"});
  endtask

  // d = number of edges after the capture edge at which done_i is presented
  task automatic txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input int d, input logic [15:0] res);
    logic        accepted;
    logic [15:0] stored;
    accepted = (op >= 3'd1) && (op <= 3'd4) && (m_cnt < BATCH);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = 8'($urandom);
    b_i     = 8'($urandom);
    repeat (d - 1) @(negedge clk_i);
    done_i   = 1'b1;
    result_i = res;
    @(negedge clk_i);
    done_i   = 1'b0;
    result_i = 16'($urandom);
    if (accepted) begin
      stored = (d <= TIMEOUT) ? res : 16'hFFFF;
      m_rec[m_cnt] = {stored, b, a, 5'd0, op};
      if (d > TIMEOUT) m_to = 1'b1;
      if ((d > TIMEOUT) || (res != ref_result(op, a, b))) begin
        if (m_mis < 65535) m_mis++;
      end
      m_cnt++;
    end
    n_txn++;
    $display("txn %0d: op=%0d a=%h b=%h delay=%0d result=%h %s cnt=%0d", n_txn, op, a, b,
             d, res, accepted ? "logged" : "ignored", m_cnt);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_res;
    int          r_d;

    reset_i  = 1'b1;
    start_i  = 1'b0;
    op_i     = '0;
    a_i      = '0;
    b_i      = '0;
    done_i   = 1'b0;
    result_i = '0;
    clear_i  = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    txn(3'd1, 8'h12, 8'h34, 1, 16'h0046);
    check_state("add");
    check("add_rec0", 64'(rec_buf_o[39:0]), 64'h00_0046_3412_01);

    txn(3'd4, 8'hFF, 8'hFF, 3, 16'hFE01);
    check_state("mul_ok");
    txn(3'd4, 8'hFF, 8'hFF, 3, 16'hFE00);
    check_state("mul_bad");
    check("mul_bad_mis", 64'(mismatch_cnt_o), 64'd1);

    txn(3'd0, 8'h01, 8'h02, 1, 16'h0003);
    check_state("noop0");
    txn(3'd6, 8'h01, 8'h02, 2, 16'h0003);
    check_state("noop6");

    txn(3'd3, 8'hA5, 8'h5A, TIMEOUT, 16'h00FF);
    check_state("done_at_limit");

    txn(3'd2, 8'hF0, 8'h3C, TIMEOUT + 4, 16'h0030);
    check_state("timeout");
    check("timeout_flag", 64'(timeout_o), 64'd1);

    for (int i = 0; i < 1000 && m_cnt < BATCH; i++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_a   = 8'($urandom);
      r_b   = 8'($urandom);
      r_d   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT + 1, TIMEOUT + 4))
                                          : int'($urandom_range(1, TIMEOUT));
      r_res = ref_result(r_op, r_a, r_b);
      if ($urandom_range(0, 3) == 0) r_res = r_res ^ 16'($urandom_range(1, 65535));
      txn(r_op, r_a, r_b, r_d, r_res);
      check_state("rand");
    end
    check("filled", 64'(full_o), 64'd1);

    txn(3'd1, 8'h01, 8'h02, 1, 16'h0003);
    check_state("overflow");

    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    model_reset();
    check_state("clear");

    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 3'd1;
    a_i     = 8'h05;
    b_i     = 8'h06;
    @(negedge clk_i);
    start_i  = 1'b0;
    done_i   = 1'b1;
    result_i = 16'h000B;
    clear_i  = 1'b1;
    @(negedge clk_i);
    done_i  = 1'b0;
    clear_i = 1'b0;
    check_state("clear_vs_done");

    txn(3'd3, 8'h0F, 8'hF0, 2, 16'h00FF);
    check_state("pre_reset");
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 3'd4;
    a_i     = 8'h03;
    b_i     = 8'h07;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    model_reset();
    check_state("async_reset");
    @(negedge clk_i);
    reset_i  = 1'b0;
    done_i   = 1'b1;
    result_i = 16'h0015;
    @(negedge clk_i);
    done_i = 1'b0;
    check_state("late_done");

    txn(3'd1, 8'h12, 8'h34, 1, 16'h0046);
    check_state("post_reset_add");
    check("post_reset_rec0", 64'(rec_buf_o[39:0]), 64'h00_0046_3412_01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_monitor.md
ALU_RESULT_MONITOR -- requirements
Module: alu_result_monitor

Interface
REQ-001 Parameter BATCH, default 100: number of transaction records held before the buffer is full.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles from command capture to done_i before a timeout is recorded.
REQ-003 The block SHALL have one clock, clk_i, with a single domain, rising edge.
REQ-004 Reset port reset_i SHALL be asynchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk_i  input  1  clock.
- reset_i  input  1  asynchronous active-high reset.
- start_i  input  1  ALU start, observed only.
- op_i  input  3  ALU opcode, observed.
- a_i  input  8  operand A, observed.
- b_i  input  8  operand B, observed.
- done_i  input  1  ALU done, observed.
- result_i  input  16  ALU result, observed.
- clear_i  input  1  synchronous buffer/counter clear.
- rec_buf_o  output  BATCH*40  packed record buffer.
- rec_cnt_o  output  $clog2(BATCH+1)  records stored.
- full_o  output  1  rec_cnt_o == BATCH.
- mismatch_cnt_o  output  16  records whose result differs from the expected value.
- timeout_o  output  1  sticky timeout flag.

Function
REQ-006 The FSM SHALL have two states, IDLE and WAIT_DONE.
REQ-007 In IDLE with start_i=1, op_i in 1..4 and full_o=0, the block SHALL latch op, A and B and enter WAIT_DONE; the timer is cleared.
REQ-008 Opcodes 0, 5, 6 and 7 SHALL be ignored (no record, no state change).
REQ-009 In WAIT_DONE, done_i=1 SHALL write a record at index rec_cnt_o, increment rec_cnt_o and return to IDLE on the same edge.
REQ-010 IDLE SHALL be held for at least one cycle after a record is written, so start_i held high captures the command present on the next cycle.
REQ-011 Record k SHALL occupy rec_buf_o[k*40+39 : k*40] with this packing:
- [2:0] op; [7:3] zero.
- [15:8] A; [23:16] B.
- [39:24] result.
REQ-012 The expected result, zero-extended to 16 bits, SHALL be:
- op1: A+B (9-bit).
- op2: A&B.
- op3: A^B.
- op4: A*B.
REQ-013 A stored result differing from the expected value SHALL increment mismatch_cnt_o, which saturates at 16'hFFFF.
REQ-014 In WAIT_DONE, if the timer reaches TIMEOUT with no done_i, the block SHALL:
- write a record with result 16'hFFFF;
- set timeout_o;
- increment mismatch_cnt_o;
- return to IDLE.
REQ-015 done_i in IDLE SHALL be ignored.
REQ-016 When full_o=1, start_i SHALL be ignored; records are never overwritten and rec_cnt_o never wraps.
REQ-017 clear_i=1 SHALL, on the next edge, zero rec_buf_o, rec_cnt_o, full_o, mismatch_cnt_o and timeout_o and force IDLE, discarding any in-flight command.
REQ-018 clear_i SHALL take priority over a simultaneous done_i or timeout.
REQ-019 full_o SHALL be a registered value equal to (rec_cnt_o == BATCH).

Reset
REQ-020 reset_i=1 SHALL immediately, without waiting for a clock edge:
- force IDLE;
- zero rec_buf_o, rec_cnt_o, full_o, mismatch_cnt_o, timeout_o, the latched command and the timer.
REQ-021 A reset during WAIT_DONE SHALL discard the in-flight command; a done_i arriving after reset release SHALL be ignored.

Verification
REQ-022 Scenario: add. op=1, A=0x12, B=0x34, done_i one cycle later with result 0x0046 -> rec_cnt_o=1, record0=40'h0046_34_12_01, mismatch_cnt_o=0.
REQ-023 Scenario: multiply. op=4, A=0xFF, B=0xFF, done_i after 3 cycles with 0xFE01 -> no mismatch. A repeat of the same command returning 0xFE00 -> mismatch_cnt_o=1, rec_cnt_o=2.
REQ-024 Scenario: no-op. start_i with op=0 or op=6 -> rec_cnt_o stays 0 and the FSM stays in IDLE.
REQ-025 Scenario: timeout. op=2 with no done_i for 16 cycles -> record result 16'hFFFF, timeout_o=1, mismatch_cnt_o=1; a late done_i is ignored.
REQ-026 Scenario: full and clear. 100 valid transactions -> full_o=1, rec_cnt_o=100; the 101st start_i is ignored. A clear_i pulse -> all outputs 0. clear_i coincident with done_i -> no record written.
REQ-027 Scenario: reset mid-operation. reset_i asserted mid-clock during WAIT_DONE -> all outputs 0 before the next edge; after release, a valid add completes normally as record0.
